// File: rtl/frame_buffer_ctrl.sv
// Frame buffer controller: display read path, host pixel writes and whole-frame fill.
// One memory write port, driven by either the host (IDLE) or the fill engine (CLEAR).
module frame_buffer_ctrl #(
    parameter int H_RES = 640,
    parameter int V_RES = 480
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  iCtrH,
    input  logic [9:0]  iCtrV,
    output logic [2:0]  rgb,
    output logic [18:0] rd_addr,
    input  logic [2:0]  rd_data,
    output logic        mem_we,
    output logic [18:0] mem_waddr,
    output logic [2:0]  mem_wdata,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [9:0]  wr_x,
    input  logic [9:0]  wr_y,
    input  logic [2:0]  wr_data,
    input  logic        clr_start,
    input  logic [2:0]  clr_color,
    output logic        clr_busy,
    output logic        err_oob
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    localparam logic [18:0] H_MUL     = 19'(H_RES);
    localparam logic [18:0] LAST_ADDR = 19'(H_RES * V_RES - 1);
    localparam logic [10:0] X_LIM     = 11'(H_RES);
    localparam logic [10:0] Y_LIM     = 11'(V_RES);

    // For H_RES=640 the constant multiply reduces to (y<<9)+(y<<7).
    function automatic logic [18:0] map_addr(input logic [9:0] y, input logic [9:0] x);
        return 19'(y) * H_MUL + 19'(x);
    endfunction

    state_t      state_r, state_nxt_s;
    logic        mem_we_r, mem_we_nxt_s;
    logic [18:0] mem_waddr_r, mem_waddr_nxt_s;
    logic [2:0]  mem_wdata_r, mem_wdata_nxt_s;
    logic        err_oob_r, err_oob_nxt_s;
    logic [18:0] fill_cnt_r, fill_cnt_nxt_s;
    logic [2:0]  fill_color_r, fill_color_nxt_s;
    logic [2:0]  rgb_r;
    logic        in_range_s;

    assign rd_addr    = map_addr(iCtrV, iCtrH);
    assign in_range_s = ({1'b0, wr_x} < X_LIM) && ({1'b0, wr_y} < Y_LIM);

    assign rgb       = rgb_r;
    assign mem_we    = mem_we_r;
    assign mem_waddr = mem_waddr_r;
    assign mem_wdata = mem_wdata_r;
    assign err_oob   = err_oob_r;
    assign wr_ready  = (state_r == ST_IDLE);
    assign clr_busy  = (state_r == ST_CLEAR);

    // Display pixel register, free-running regardless of write activity.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rgb_r <= 3'b000;
        end else begin
            rgb_r <= rd_data;
        end
    end

    // Next-state and next write-port values.
    always_comb begin
        state_nxt_s      = state_r;
        mem_we_nxt_s     = 1'b0;
        mem_waddr_nxt_s  = mem_waddr_r;
        mem_wdata_nxt_s  = mem_wdata_r;
        err_oob_nxt_s    = 1'b0;
        fill_cnt_nxt_s   = fill_cnt_r;
        fill_color_nxt_s = fill_color_r;
        case (state_r)
            ST_IDLE: begin
                if (wr_valid) begin
                    if (in_range_s) begin
                        mem_we_nxt_s    = 1'b1;
                        mem_waddr_nxt_s = map_addr(wr_y, wr_x);
                        mem_wdata_nxt_s = wr_data;
                    end else begin
                        err_oob_nxt_s = 1'b1;
                    end
                end else begin
                    mem_we_nxt_s = 1'b0;
                end
                // A coincident host write goes out first; the fill follows next cycle.
                if (clr_start) begin
                    state_nxt_s      = ST_CLEAR;
                    fill_color_nxt_s = clr_color;
                    fill_cnt_nxt_s   = 19'd0;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                mem_we_nxt_s    = 1'b1;
                mem_waddr_nxt_s = fill_cnt_r;
                mem_wdata_nxt_s = fill_color_r;
                if (fill_cnt_r == LAST_ADDR) begin
                    state_nxt_s    = ST_IDLE;
                    fill_cnt_nxt_s = 19'd0;
                end else begin
                    fill_cnt_nxt_s = fill_cnt_r + 19'd1;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, fill bookkeeping and registered write port.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= ST_IDLE;
            mem_we_r     <= 1'b0;
            mem_waddr_r  <= 19'd0;
            mem_wdata_r  <= 3'b000;
            err_oob_r    <= 1'b0;
            fill_cnt_r   <= 19'd0;
            fill_color_r <= 3'b000;
        end else begin
            state_r      <= state_nxt_s;
            mem_we_r     <= mem_we_nxt_s;
            mem_waddr_r  <= mem_waddr_nxt_s;
            mem_wdata_r  <= mem_wdata_nxt_s;
            err_oob_r    <= err_oob_nxt_s;
            fill_cnt_r   <= fill_cnt_nxt_s;
            fill_color_r <= fill_color_nxt_s;
        end
    end

endmodule

// File: tb/tb_frame_buffer_ctrl.sv
// Bench for frame_buffer_ctrl: full-size instance for mapping/latency checks and a
// small-geometry instance so a complete fill fits in a short run.
module tb_frame_buffer_ctrl;

    localparam int HS = 16;
    localparam int VS = 12;
    localparam int NS = HS * VS;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  ictr_h, ictr_v;
    logic        wr_valid;
    logic [9:0]  wr_x, wr_y;
    logic [2:0]  wr_data;
    logic        clr_start;
    logic [2:0]  clr_color;

    logic [2:0]  rgb_a, rd_data_a, wdata_a;
    logic [18:0] rd_addr_a, waddr_a;
    logic        we_a, ready_a, busy_a, oob_a;
    logic [2:0]  rgb_b, rd_data_b, wdata_b;
    logic [18:0] rd_addr_b, waddr_b;
    logic        we_b, ready_b, busy_b, oob_b;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    frame_buffer_ctrl dut_a (
        .clk(clk), .rst(rst), .iCtrH(ictr_h), .iCtrV(ictr_v), .rgb(rgb_a),
        .rd_addr(rd_addr_a), .rd_data(rd_data_a), .mem_we(we_a), .mem_waddr(waddr_a),
        .mem_wdata(wdata_a), .wr_valid(wr_valid), .wr_ready(ready_a), .wr_x(wr_x),
        .wr_y(wr_y), .wr_data(wr_data), .clr_start(clr_start), .clr_color(clr_color),
        .clr_busy(busy_a), .err_oob(oob_a)
    );

    frame_buffer_ctrl #(.H_RES(HS), .V_RES(VS)) dut_b (
        .clk(clk), .rst(rst), .iCtrH(ictr_h), .iCtrV(ictr_v), .rgb(rgb_b),
        .rd_addr(rd_addr_b), .rd_data(rd_data_b), .mem_we(we_b), .mem_waddr(waddr_b),
        .mem_wdata(wdata_b), .wr_valid(wr_valid), .wr_ready(ready_b), .wr_x(wr_x),
        .wr_y(wr_y), .wr_data(wr_data), .clr_start(clr_start), .clr_color(clr_color),
        .clr_busy(busy_b), .err_oob(oob_b)
    );

    // Unwritten locations read back a fixed address-derived pattern.
    function automatic logic [2:0] pat(input logic [18:0] a);
        return a[2:0] ^ a[5:3];
    endfunction

    logic [2:0] mem_a [0:307199];
    bit         wrt_a [0:307199];
    logic [2:0] mem_b [0:NS-1];

    // Synchronous-read frame memories (read-before-write).
    always @(posedge clk) begin
        if (we_a && waddr_a < 19'd307200) begin
            mem_a[waddr_a] <= wdata_a;
            wrt_a[waddr_a] <= 1'b1;
        end
        rd_data_a <= (rd_addr_a < 19'd307200 && wrt_a[rd_addr_a]) ? mem_a[rd_addr_a] : pat(rd_addr_a);
        if (we_b && waddr_b < 19'(NS)) mem_b[waddr_b] <= wdata_b;
        rd_data_b <= (rd_addr_b < 19'(NS)) ? mem_b[rd_addr_b] : 3'b000;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    typedef struct {
        logic        v;
        logic [9:0]  x;
        logic [9:0]  y;
        logic [2:0]  d;
        logic        e_we;
        logic [18:0] e_addr;
        logic        e_oob;
    } vec_t;

    vec_t tbl [0:10];

    initial begin
        logic [18:0] exp_addr, prev_exp_addr;
        logic [2:0]  prev_exp_rgb;
        logic        exp_we, exp_oob, exp_busy_b;
        int          busy_cnt_b;

        tbl[0]  = '{1'b1, 10'd639,  10'd479,  3'b011, 1'b1, 19'd307199, 1'b0};
        tbl[1]  = '{1'b1, 10'd0,    10'd0,    3'b111, 1'b1, 19'd0,      1'b0};
        tbl[2]  = '{1'b1, 10'd640,  10'd0,    3'b001, 1'b0, 19'd0,      1'b1};
        tbl[3]  = '{1'b0, 10'd5,    10'd5,    3'b010, 1'b0, 19'd0,      1'b0};
        tbl[4]  = '{1'b1, 10'd5,    10'd2,    3'b100, 1'b1, 19'd1285,   1'b0};
        tbl[5]  = '{1'b1, 10'd0,    10'd1,    3'b001, 1'b1, 19'd640,    1'b0};
        tbl[6]  = '{1'b1, 10'd100,  10'd200,  3'b110, 1'b1, 19'd128100, 1'b0};
        tbl[7]  = '{1'b1, 10'd0,    10'd480,  3'b101, 1'b0, 19'd0,      1'b1};
        tbl[8]  = '{1'b1, 10'd1023, 10'd1023, 3'b011, 1'b0, 19'd0,      1'b1};
        tbl[9]  = '{1'b1, 10'd639,  10'd0,    3'b010, 1'b1, 19'd639,    1'b0};
        tbl[10] = '{1'b0, 10'd0,    10'd0,    3'b000, 1'b0, 19'd0,      1'b0};

        rst = 1'b0; ictr_h = 10'd0; ictr_v = 10'd0; wr_valid = 1'b0;
        wr_x = 10'd0; wr_y = 10'd0; wr_data = 3'b000; clr_start = 1'b0; clr_color = 3'b000;
        cyc(); cyc();
        chk("rst_rgb", rgb_a, 0);     chk("rst_we", we_a, 0);
        chk("rst_waddr", waddr_a, 0); chk("rst_wdata", wdata_a, 0);
        chk("rst_busy", busy_a, 0);   chk("rst_oob", oob_a, 0);
        chk("rst_ready", ready_a, 1);
        rst = 1'b1;
        cyc();

        // Display read of address 1285 and its two-cycle latency
        ictr_h = 10'd5; ictr_v = 10'd2;
        #1 chk("rdaddr_1285", rd_addr_a, 1285);
        cyc();
        ictr_h = 10'd3; ictr_v = 10'd0;
        cyc();
        chk("rgb_1285_lat2", rgb_a, 3'b101);

        // Randomised display scan against the address-pattern model
        prev_exp_rgb = 3'b000;
        for (int i = 0; i < 200; i++) begin
            ictr_h = 10'($urandom_range(0, 639));
            ictr_v = 10'($urandom_range(0, 479));
            exp_addr = 19'(int'(ictr_v) * 640 + int'(ictr_h));
            #1 chk("rand_rdaddr", rd_addr_a, exp_addr);
            cyc();
            if (i > 0) chk("rand_rgb", rgb_a, prev_exp_rgb);
            prev_exp_rgb = pat(exp_addr);
        end

        // Host write vectors, back-to-back, one result per cycle
        for (int i = 0; i <= 10; i++) begin
            wr_valid = tbl[i].v; wr_x = tbl[i].x; wr_y = tbl[i].y; wr_data = tbl[i].d;
            #1 chk("tbl_ready", ready_a, 1);
            cyc();
            chk("tbl_we", we_a, tbl[i].e_we);
            chk("tbl_oob", oob_a, tbl[i].e_oob);
            if (tbl[i].e_we) begin
                chk("tbl_waddr", waddr_a, tbl[i].e_addr);
                chk("tbl_wdata", wdata_a, tbl[i].d);
            end
        end

        // Randomised host writes against the coordinate model
        for (int i = 0; i < 400; i++) begin
            wr_valid = 1'($urandom_range(0, 1));
            wr_x = 10'($urandom_range(0, 700));
            wr_y = 10'($urandom_range(0, 520));
            wr_data = 3'($urandom);
            exp_we  = wr_valid && (wr_x < 10'd640) && (wr_y < 10'd480);
            exp_oob = wr_valid && !exp_we;
            exp_addr = 19'(int'(wr_y) * 640 + int'(wr_x));
            cyc();
            chk("rnd_we", we_a, exp_we);
            chk("rnd_oob", oob_a, exp_oob);
            if (exp_we) begin
                chk("rnd_waddr", waddr_a, exp_addr);
                chk("rnd_wdata", wdata_a, wr_data);
            end
        end
        wr_valid = 1'b0;
        cyc();
        chk("idle_we", we_a, 0);

        // Fill: small instance runs to completion, full-size one is reset at address 1000
        clr_start = 1'b1; clr_color = 3'b110;
        cyc();
        clr_start = 1'b0; clr_color = 3'b000;
        chk("fill_busy_a", busy_a, 1); chk("fill_ready_a", ready_a, 0);
        chk("fill_we_first", we_a, 0); chk("fill_busy_b", busy_b, 1);
        busy_cnt_b = 1;
        for (int k = 0; k <= 1000; k++) begin
            cyc();
            clr_start = (k == 50);
            clr_color = 3'b001;
            chk("fillA_we", we_a, 1); chk("fillA_addr", waddr_a, k);
            chk("fillA_data", wdata_a, 3'b110); chk("fillA_ready", ready_a, 0);
            if (k <= NS + 1) begin
                exp_we = (k < NS);
                exp_busy_b = (k + 2 <= NS);
                chk("fillB_we", we_b, exp_we);
                if (exp_we) begin
                    chk("fillB_addr", waddr_b, k);
                    chk("fillB_data", wdata_b, 3'b110);
                end
                chk("fillB_busy", busy_b, exp_busy_b);
                chk("fillB_ready", ready_b, !exp_busy_b);
                if (busy_b) busy_cnt_b++;
            end
        end
        clr_start = 1'b0;
        chk("fillB_busy_cycles", busy_cnt_b, NS);

        rst = 1'b0;
        #1 chk("abort_we", we_a, 0); chk("abort_busy", busy_a, 0); chk("abort_rgb", rgb_a, 0);
        cyc();
        chk("abort_we_held", we_a, 0); chk("abort_rgb_held", rgb_a, 0);
        rst = 1'b1;
        #1 chk("post_rst_ready", ready_a, 1); chk("post_rst_busy", busy_a, 0);
        cyc();
        chk("post_rst_we", we_a, 0);

        // Coincident host write and fill request
        wr_valid = 1'b1; wr_x = 10'd10; wr_y = 10'd0; wr_data = 3'b010;
        clr_start = 1'b1; clr_color = 3'b011;
        cyc();
        wr_valid = 1'b0; clr_start = 1'b0;
        chk("sim_we", we_a, 1); chk("sim_waddr", waddr_a, 10); chk("sim_wdata", wdata_a, 3'b010);
        chk("sim_busy", busy_a, 1); chk("sim_ready", ready_a, 0);
        cyc();
        chk("sim_fill0_we", we_a, 1); chk("sim_fill0_addr", waddr_a, 0);
        chk("sim_fill0_data", wdata_a, 3'b011);
        cyc();
        chk("sim_fill1_addr", waddr_a, 1);
        rst = 1'b0;
        cyc();
        rst = 1'b1;
        cyc();
        chk("final_we", we_a, 0); chk("final_ready", ready_a, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
